sipo_frame_ctrl: RTL and testbench
==================================

Name: sipo_frame_ctrl

Overview:
- Sequences the byte-assembly SIPO on the Viterbi decoder output path.
- Accepts decoded bits from the traceback unit over a valid/ready handshake, gates them into the SIPO, and captures each assembled byte into a one-entry hold register.
- Presents bytes downstream with valid/ready and a last-byte flag, and enforces a per-frame byte count.
- Backpressure from the downstream consumer propagates to the decoder through bit_ready_o.

Parameters:
LEN_W, 8, width of frame_len_i; max frame = 2^LEN_W-1 bytes.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  asynchronous active-high reset; top level drives the SIPO's rst_n from ~rst.
start_i  input  1  frame start pulse; honoured only in IDLE.
frame_len_i  input  LEN_W  frame length in bytes; sampled when start_i is honoured.
bit_i  input  1  decoded bit, MSB of each byte first.
bit_valid_i  input  1  bit_i valid.
bit_ready_o  output  1  controller can accept a bit this cycle.
sipo_data_o  output  1  serial data to SIPO (= bit_i).
sipo_valid_o  output  1  serial valid to SIPO (= bit_valid_i & bit_ready_o).
sipo_byte_i  input  8  SIPO parallel output.
sipo_byte_ready_i  input  1  SIPO one-cycle byte-complete pulse.
byte_o  output  8  held byte.
byte_valid_o  output  1  hold register full.
byte_last_o  output  1  held byte is the final byte of the frame.
byte_ready_i  input  1  downstream accepts byte_o.
busy_o  output  1  state != IDLE.
done_o  output  1  one-cycle pulse at frame completion.
err_o  output  1  sticky: unexpected sipo_byte_ready_i; cleared by rst or an honoured start_i.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; hold register empty.
- Bit handshake: a bit is accepted on an edge where bit_valid_i & bit_ready_o are both 1. sipo_valid_o and sipo_data_o are combinational.
- Counters:
  - bits_left (LEN_W+3 bits), loaded with frame_len_i*8 on start; decrements per accepted bit.
  - bit_cnt (3 bits) wraps 7->0.
  - in_flight flag: set when a bit with bit_cnt==7 is accepted; cleared on sipo_byte_ready_i.
- bit_ready_o = (state==RUN) & (bits_left!=0) & !(bit_cnt==7 & (byte_valid_o | in_flight)). This guarantees the hold register is free when a byte completes, with no loss or overwrite.
- Capture: on an edge with sipo_byte_ready_i=1, load byte_o <= sipo_byte_i, set byte_valid_o, clear in_flight. byte_last_o <= (bits_left==0) at capture.
- Latency: 8th-bit accept edge t -> SIPO pulse in cycle t+1 -> byte_valid_o high from cycle t+2.
- Release: byte_valid_o clears on an edge with byte_ready_i=1. If capture and release fall on the same edge, capture wins (valid stays 1, new data).
- sipo_byte_ready_i while in_flight=0 sets err_o. The byte is still captured if the hold register is empty, and dropped otherwise.
- FSM:
  - IDLE: start_i & frame_len_i!=0 -> RUN. start_i & frame_len_i==0 -> DONE.
  - RUN: bits_left==0 after the last accept -> DRAIN.
  - DRAIN: last byte accepted downstream (byte_valid_o & byte_last_o & byte_ready_i) -> DONE.
  - DONE: done_o=1 for one cycle -> IDLE.
- start_i outside IDLE is ignored; frame_len_i is not re-sampled.
- bit_valid_i outside RUN is ignored; bit_ready_o=0.
- Reset mid-frame: immediate return to IDLE, hold register emptied, counters cleared. The SIPO is reset concurrently, so bit alignment restarts at the MSB.

Test Plan:
- start_i, frame_len_i=2, bits 10101010 11110000 back-to-back, byte_ready_i=1 -> byte_o=0xAA (last=0), then 0xF0 (last=1); done_o pulse; bit_ready_o=0 after 16 bits.
- frame_len_i=2, byte_ready_i=0 held -> 8th bit of byte 2 stalls (bit_ready_o=0 with bit_cnt==7); byte_o stays 0xAA; raising byte_ready_i resumes; no byte lost.
- Bits with bit_valid_i gaps (4 valid, 2 idle, 4 valid) -> byte_o=0xF0, byte_valid_o 2 cycles after the 8th accept.
- frame_len_i=0 -> done_o 1 cycle after start, no bytes emitted; start_i during RUN -> ignored, byte count unchanged.
- rst pulsed after 3 bits -> all outputs 0, IDLE; new frame with 0x5A -> byte_o=0x5A.
- Forced sipo_byte_ready_i pulse with in_flight=0 -> err_o=1 and sticky until next honoured start_i.

Source files
------------

// File: rtl/sipo_frame_ctrl_if.sv
// Handshake and data bundle between the byte-assembly frame controller and its neighbours.
// slave: controller view; master: the surrounding decoder/SIPO/consumer view.
interface sipo_frame_ctrl_if #(
  parameter int LEN_W = 8
) ();
  logic             start_i;
  logic [LEN_W-1:0] frame_len_i;
  logic             bit_i;
  logic             bit_valid_i;
  logic             bit_ready_o;
  logic             sipo_data_o;
  logic             sipo_valid_o;
  logic [7:0]       sipo_byte_i;
  logic             sipo_byte_ready_i;
  logic [7:0]       byte_o;
  logic             byte_valid_o;
  logic             byte_last_o;
  logic             byte_ready_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  modport slave (
    input  start_i, frame_len_i, bit_i, bit_valid_i,
    input  sipo_byte_i, sipo_byte_ready_i, byte_ready_i,
    output bit_ready_o, sipo_data_o, sipo_valid_o,
    output byte_o, byte_valid_o, byte_last_o, busy_o, done_o, err_o
  );

  modport master (
    output start_i, frame_len_i, bit_i, bit_valid_i,
    output sipo_byte_i, sipo_byte_ready_i, byte_ready_i,
    input  bit_ready_o, sipo_data_o, sipo_valid_o,
    input  byte_o, byte_valid_o, byte_last_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Frame controller for the Viterbi output byte-assembly SIPO: gates decoded bits into the
// SIPO, holds each assembled byte for the consumer, and enforces the per-frame byte count.
module sipo_frame_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  sipo_frame_ctrl_if.slave bus
);
  localparam int CNT_W = LEN_W + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] bits_left_reg, bits_left_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic             in_flight_reg, in_flight_next;
  logic [7:0]       byte_reg, byte_next;
  logic             byte_valid_reg, byte_valid_next;
  logic             byte_last_reg, byte_last_next;
  logic             err_reg, err_next;

  logic             busy;
  logic             done;
  logic             start_ok;
  logic             bit_ready;
  logic             bit_accept;
  logic             stray_pulse;
  logic             capture;
  logic             release_byte;
  logic             last_release;
  logic [CNT_W-1:0] frame_bits;

  assign frame_bits = {bus.frame_len_i, 3'b000};
  assign start_ok   = (state_reg == IDLE) && bus.start_i;

  // The 8th bit of a byte is held back while the previous byte still occupies the
  // SIPO pipeline or the hold register, so a completed byte always finds the hold free.
  assign bit_ready    = (state_reg == RUN) && (bits_left_reg != '0) &&
                        !((bit_cnt_reg == 3'd7) && (byte_valid_reg || in_flight_reg));
  assign bit_accept   = bus.bit_valid_i && bit_ready;
  assign stray_pulse  = bus.sipo_byte_ready_i && !in_flight_reg;
  assign capture      = bus.sipo_byte_ready_i && (in_flight_reg || !byte_valid_reg);
  assign release_byte = byte_valid_reg && bus.byte_ready_i;
  assign last_release = release_byte && byte_last_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    done       = (state_reg == DONE);
    case (state_reg)
      IDLE: begin
        if (bus.start_i) begin
          state_next = (bus.frame_len_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (bits_left_reg == '0) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_release) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    bits_left_next  = bits_left_reg;
    bit_cnt_next    = bit_cnt_reg;
    in_flight_next  = in_flight_reg;
    byte_next       = byte_reg;
    byte_valid_next = byte_valid_reg;
    byte_last_next  = byte_last_reg;
    err_next        = err_reg;

    if (start_ok) begin
      bits_left_next = frame_bits;
      bit_cnt_next   = 3'd0;
      in_flight_next = 1'b0;
      err_next       = 1'b0;
    end

    if (bit_accept) begin
      bits_left_next = bits_left_reg - CNT_W'(1);
      bit_cnt_next   = bit_cnt_reg + 3'd1;
    end

    if (bus.sipo_byte_ready_i) begin
      in_flight_next = 1'b0;
    end
    if (bit_accept && (bit_cnt_reg == 3'd7)) begin
      in_flight_next = 1'b1;
    end

    if (stray_pulse) begin
      err_next = 1'b1;
    end

    // Capture after release so a same-edge capture keeps the register full with new data.
    if (release_byte) begin
      byte_valid_next = 1'b0;
    end
    if (capture) begin
      byte_next       = bus.sipo_byte_i;
      byte_valid_next = 1'b1;
      byte_last_next  = (bits_left_reg == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_left_reg  <= '0;
      bit_cnt_reg    <= 3'd0;
      in_flight_reg  <= 1'b0;
      byte_reg       <= 8'h00;
      byte_valid_reg <= 1'b0;
      byte_last_reg  <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      bits_left_reg  <= bits_left_next;
      bit_cnt_reg    <= bit_cnt_next;
      in_flight_reg  <= in_flight_next;
      byte_reg       <= byte_next;
      byte_valid_reg <= byte_valid_next;
      byte_last_reg  <= byte_last_next;
      err_reg        <= err_next;
    end
  end

  assign bus.bit_ready_o  = bit_ready;
  assign bus.sipo_data_o  = bus.bit_i;
  assign bus.sipo_valid_o = bit_accept;
  assign bus.byte_o       = byte_reg;
  assign bus.byte_valid_o = byte_valid_reg;
  assign bus.byte_last_o  = byte_last_reg;
  assign bus.busy_o       = busy;
  assign bus.done_o       = done;
  assign bus.err_o        = err_reg;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: a behavioural SIPO feeds bytes back, and a frame-level model
// (byte queue plus sent/released counts) predicts handshakes, data, last flags and timing.
module tb_sipo_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sipo_frame_ctrl_if #(.LEN_W(8)) bus ();
  sipo_frame_ctrl #(.LEN_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural SIPO: shifts MSB first, pulses one cycle after the 8th bit.
  logic [7:0] sipo_sh, sipo_byte_q;
  logic [2:0] sipo_cnt;
  logic       sipo_pulse;
  logic       force_pulse = 1'b0;
  logic [7:0] force_byte  = 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sipo_sh     <= 8'h00;
      sipo_byte_q <= 8'h00;
      sipo_cnt    <= 3'd0;
      sipo_pulse  <= 1'b0;
    end else begin
      sipo_pulse <= 1'b0;
      if (bus.sipo_valid_o) begin
        sipo_sh  <= {sipo_sh[6:0], bus.sipo_data_o};
        sipo_cnt <= sipo_cnt + 3'd1;
        if (sipo_cnt == 3'd7) begin
          sipo_byte_q <= {sipo_sh[6:0], bus.sipo_data_o};
          sipo_pulse  <= 1'b1;
        end
      end
    end
  end

  assign bus.sipo_byte_ready_i = sipo_pulse | force_pulse;
  assign bus.sipo_byte_i       = force_pulse ? force_byte : sipo_byte_q;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] frame_q[$];

  task automatic check1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic checkn(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start_i      = 1'b0;
    bus.bit_valid_i  = 1'b0;
    bus.bit_i        = 1'b0;
    bus.byte_ready_i = 1'b0;
  endtask

  // Runs the frame held in frame_q. Expected bit_ready: bits remain and not (8th bit of a
  // byte while an earlier completed byte has not yet been taken downstream).
  task automatic run_frame(input string name, input bit use_mask, input logic [63:0] vmask,
                           input int valid_pct, input int ready_pct, input int hold,
                           input bit stray_start);
    int         n, total, sent, released, cyc;
    int         acc8[16];
    bit         head_seen, bv, br;
    logic       exp_ready;
    logic [7:0] cur;
    n         = frame_q.size();
    total     = n * 8;
    sent      = 0;
    released  = 0;
    cyc       = 0;
    head_seen = 1'b0;
    for (int i = 0; i < 16; i++) acc8[i] = -100;
    $display("frame %s: start, %0d bytes", name, n);
    bus.frame_len_i = 8'(n);
    bus.start_i     = 1'b1;
    step();
    bus.start_i = 1'b0;
    check1("err_clear_on_start", bus.err_o, 1'b0);
    check1("busy_after_start", bus.busy_o, 1'b1);
    while (released < n && cyc < 2000) begin
      bv = use_mask ? vmask[6'(cyc)] : ($urandom_range(99) < valid_pct);
      br = (cyc < hold) ? 1'b0 : ($urandom_range(99) < ready_pct);
      if (sent < total) begin
        cur = frame_q[sent / 8];
        bus.bit_i = cur[3'(7 - sent % 8)];
      end else begin
        bus.bit_i = 1'($urandom);
      end
      bus.bit_valid_i  = bv;
      bus.byte_ready_i = br;
      bus.start_i      = stray_start && (cyc == 5);
      bus.frame_len_i  = (stray_start && cyc == 5) ? 8'd7 : 8'(n);
      #1;
      exp_ready = (sent < total) && !((sent % 8 == 7) && (sent / 8 - released != 0));
      check1("bit_ready", bus.bit_ready_o, exp_ready);
      check1("sipo_valid", bus.sipo_valid_o, bv && exp_ready);
      check1("done_low_mid_frame", bus.done_o, 1'b0);
      if (hold != 0 && cyc == hold - 1) begin
        checkn("stall_bits_sent", 32'(sent), 32'((total < 15) ? total : 15));
        checkn("stall_byte_held", 32'(bus.byte_o), 32'(frame_q[0]));
      end
      if (bus.byte_valid_o === 1'b1 && released < n) begin
        if (!head_seen) begin
          checkn("byte_valid_latency", 32'(cyc), 32'(acc8[released] + 2));
          head_seen = 1'b1;
        end
        checkn("byte_data", 32'(bus.byte_o), 32'(frame_q[released]));
        check1("byte_last", bus.byte_last_o, released == n - 1);
        if (br) begin
          $display("frame %s: byte %0d = %02h last=%0b", name, released, bus.byte_o, bus.byte_last_o);
          released++;
          head_seen = 1'b0;
        end
      end
      if (bv && exp_ready) begin
        if (sent % 8 == 7) acc8[sent / 8] = cyc;
        sent++;
      end
      step();
      cyc++;
    end
    drive_idle();
    bus.frame_len_i = 8'd0;
    checkn("frame_bytes_released", 32'(released), 32'(n));
    checkn("frame_bits_sent", 32'(sent), 32'(total));
    check1("done_pulse", bus.done_o, 1'b1);
    check1("hold_empty_at_done", bus.byte_valid_o, 1'b0);
    step();
    check1("done_clears", bus.done_o, 1'b0);
    check1("idle_after_frame", bus.busy_o, 1'b0);
    $display("frame %s: done after %0d cycles", name, cyc);
  endtask

  initial begin
    drive_idle();
    bus.frame_len_i = 8'd0;

    // Reset state
    step();
    check1("rst_busy", bus.busy_o, 1'b0);
    check1("rst_done", bus.done_o, 1'b0);
    check1("rst_err", bus.err_o, 1'b0);
    check1("rst_byte_valid", bus.byte_valid_o, 1'b0);
    check1("rst_bit_ready", bus.bit_ready_o, 1'b0);
    checkn("rst_byte", 32'(bus.byte_o), 32'h0);
    rst = 1'b0;
    step();

    // Back-to-back AA F0 with consumer always ready
    frame_q = '{8'hAA, 8'hF0};
    run_frame("aa_f0", 1'b1, {64{1'b1}}, 100, 100, 0, 1'b0);

    // Same frame with consumer stalled: 8th bit of byte 2 must wait
    frame_q = '{8'hAA, 8'hF0};
    run_frame("stall", 1'b1, {64{1'b1}}, 100, 100, 30, 1'b0);

    // 4 valid, 2 idle, 4 valid
    frame_q = '{8'hF0};
    run_frame("gaps", 1'b1, ~64'h30, 100, 100, 0, 1'b0);

    // Zero-length frame
    bus.frame_len_i = 8'd0;
    bus.start_i     = 1'b1;
    step();
    bus.start_i = 1'b0;
    check1("len0_done", bus.done_o, 1'b1);
    check1("len0_busy", bus.busy_o, 1'b1);
    check1("len0_no_byte", bus.byte_valid_o, 1'b0);
    step();
    check1("len0_done_clears", bus.done_o, 1'b0);
    check1("len0_idle", bus.busy_o, 1'b0);
    $display("frame len0: done pulse, no bytes");

    // Reset after 3 accepted bits
    bus.frame_len_i = 8'd1;
    bus.start_i     = 1'b1;
    step();
    bus.start_i     = 1'b0;
    bus.bit_valid_i = 1'b1;
    bus.bit_i       = 1'b1;
    repeat (3) step();
    bus.bit_valid_i = 1'b0;
    bus.bit_i       = 1'b0;
    rst = 1'b1;
    #1;
    check1("midrst_busy", bus.busy_o, 1'b0);
    check1("midrst_bit_ready", bus.bit_ready_o, 1'b0);
    check1("midrst_byte_valid", bus.byte_valid_o, 1'b0);
    check1("midrst_done", bus.done_o, 1'b0);
    check1("midrst_err", bus.err_o, 1'b0);
    checkn("midrst_byte", 32'(bus.byte_o), 32'h0);
    step();
    rst = 1'b0;
    step();
    $display("frame midrst: reset after 3 bits");
    frame_q = '{8'h5A};
    run_frame("after_rst", 1'b1, {64{1'b1}}, 100, 100, 0, 1'b0);

    // Unexpected SIPO pulses: first captured into the empty hold, second dropped
    force_byte  = 8'h33;
    force_pulse = 1'b1;
    step();
    force_pulse = 1'b0;
    check1("stray_err_set", bus.err_o, 1'b1);
    check1("stray_captured", bus.byte_valid_o, 1'b1);
    checkn("stray_byte", 32'(bus.byte_o), 32'h33);
    force_byte  = 8'h44;
    force_pulse = 1'b1;
    step();
    force_pulse = 1'b0;
    checkn("stray_dropped", 32'(bus.byte_o), 32'h33);
    repeat (3) step();
    check1("err_sticky", bus.err_o, 1'b1);
    bus.byte_ready_i = 1'b1;
    step();
    bus.byte_ready_i = 1'b0;
    check1("stray_released", bus.byte_valid_o, 1'b0);
    check1("err_sticky_after_release", bus.err_o, 1'b1);
    $display("stray pulses: err raised, second byte dropped");

    // Random frames under random valid/ready, first one with an ignored start mid-frame
    for (int f = 0; f < 5; f++) begin
      int nb;
      nb = int'($urandom_range(5, 1));
      frame_q.delete();
      for (int b = 0; b < nb; b++) frame_q.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", f), 1'b0, 64'h0, 70, 60, 0, f == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
